// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_pkg
// Shared definitions for the bit-serial add/subtract controller:
//   - state_e : controller state encoding (IDLE, RUN, DONE)
//   - OP_ADD / OP_SUB : values of the 'sub' opcode input
// -----------------------------------------------------------------------------
package serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage : serial_add_ctrl_pkg

// File: rtl/serial_add_ctrl_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Combinational 1-bit full adder, the single arithmetic cell reused once per
// bit position by serial_add_ctrl.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   s     : sum bit   (a ^ b ^ cin)
//   cout  : carry out (majority of a, b, cin)
// -----------------------------------------------------------------------------
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial add/subtract controller. On an accepted start the operands are
// loaded into shift registers and fed LSB first through one full_adder_cell,
// one bit per clock, with the carry held in a register between bits. After
// WIDTH cycles the assembled result, carry out and signed overflow are
// registered and 'done' pulses for one cycle.
// Parameters:
//   WIDTH : operand/result width in bits (>= 2)
// Ports:
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   start : request, sampled only in IDLE
//   sub   : 0 = a+b, 1 = a-b, captured with start
//   a, b  : operands, captured with start
//   busy  : high while the operation runs (RUN)
//   done  : one-cycle pulse, result valid
//   sum   : result, held until the next accepted start
//   cout  : final carry out (subtract: 1 = no borrow, a >= b unsigned)
//   ovf   : two's-complement overflow
// -----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             carry_q, carry_d;
  logic             cmsb_q,  cmsb_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic cell_s;
  logic cell_c;

  full_adder_cell u_cell (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (carry_q),
    .s   (cell_s),
    .cout(cell_c)
  );

  // NOTE: every signal gets its hold value first so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
          a_sh_d  = a;
          b_sh_d  = (sub == OP_SUB) ? ~b : b;
          carry_d = sub;
          res_d   = '0;
          cmsb_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        res_d   = {cell_s, res_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = cell_c;
        cnt_d   = cnt_q + 1'b1;

        // Carry out of bit WIDTH-2 is the carry into the MSB; kept for the
        // signed overflow test (carry-in of MSB differs from carry-out).
        if (cnt_q == CNT_PREV) begin
          cmsb_d = cell_c;
        end

        if (cnt_q == CNT_LAST) begin
          sum_d   = {cell_s, res_q[WIDTH-1:1]};
          cout_d  = cell_c;
          ovf_d   = cmsb_q ^ cell_c;
          // Counter is left at its last value so it never wraps.
          cnt_d   = cnt_q;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are registered from the next state so they line up
    // with the state they describe.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (WIDTH = 8): a table of directed
// add/subtract vectors with hand-computed results, plus hand-written
// sequences for ignored starts, operand changes after capture and reset in
// the middle of an operation.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks;
  int n_pass;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, optionally scrambling the inputs every cycle after
  // capture, and check latency, busy length, result and the one-cycle done.
  task automatic run_op(input vec_t v, input bit scramble);
    int cycles;
    int busy_cnt;
    start = 1'b1;
    sub   = v.sub;
    a     = v.a;
    b     = v.b;
    step();                       // E0: operands captured
    start    = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    while (!done && cycles < 4 * W) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
      end
      step();
      cycles++;
    end
    check("done_latency", 32'(cycles), 32'(W));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("sum", 32'(sum), 32'(v.sum));
    check("cout", 32'(cout), 32'(v.cout));
    check("ovf", 32'(ovf), 32'(v.ovf));
    step();
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    int done_cnt;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    sub      = 1'b0;
    a        = '0;
    b        = '0;

    //        sub   a      b      sum    cout  ovf
    vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h40, 8'h40, 8'h80, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0};

    // Reset, then idle.
    repeat (3) step();
    rst_n = 1'b1;
    repeat (5) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i], 1'b0);
    end

    // 0x01+0x01 with starts pulsed in RUN cycle 3 and during DONE.
    start = 1'b1; sub = 1'b0; a = 8'h01; b = 8'h01;
    step();                       // E0
    start    = 1'b0;
    done_cnt = 0;
    for (int i = 1; i <= W + 4; i++) begin
      step();
      if (done) done_cnt++;
      start = (i == 2) || done;
      if (start) begin
        a = 8'hAA;
        b = 8'h55;
      end
    end
    start = 1'b0;
    check("ignored_start_done_count", 32'(done_cnt), 32'd1);
    check("ignored_start_sum", 32'(sum), 32'h02);
    check("ignored_start_busy", 32'(busy), 32'd0);
    v = '{1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
    run_op(v, 1'b0);

    // Inputs scrambled every cycle after capture.
    run_op(vecs[0], 1'b1);
    v = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    run_op(v, 1'b1);

    // Reset during RUN cycle 4.
    start = 1'b1; sub = 1'b0; a = 8'h12; b = 8'h34;
    step();                       // E0
    start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_sum", 32'(sum), 32'd0);
    check("midrun_rst_cout", 32'(cout), 32'd0);
    check("midrun_rst_ovf", 32'(ovf), 32'd0);
    rst_n    = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < W + 4; i++) begin
      step();
      if (done || busy) done_cnt++;
    end
    check("midrun_rst_no_activity", 32'(done_cnt), 32'd0);
    v = '{1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
    run_op(v, 1'b0);

    // Reset and start together resolves as reset.
    rst_n = 1'b0;
    start = 1'b1;
    step();
    rst_n = 1'b1;
    start = 1'b0;
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_sum", 32'(sum), 32'd0);
    step();
    check("rst_start_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_serial_add_ctrl
